// File: rtl/snake_ram_arbiter_if.sv
// Snake RAM port-A bundle: three requester channels, clear control and the RAM pins.
// slave = arbiter side, master = play-core requesters plus RAM.
interface snake_ram_arbiter_if #(
    parameter int AW = 13,
    parameter int DW = 16
);
    logic          req_a, req_b, req_f;
    logic          we_a, we_b, we_f;
    logic [AW-1:0] addr_a, addr_b, addr_f;
    logic [DW-1:0] wdata_a, wdata_b, wdata_f;
    logic          ack_a, ack_b, ack_f;
    logic [DW-1:0] rdata;
    logic          clear_start;
    logic          clear_done;
    logic          busy;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  req_a, req_b, req_f, we_a, we_b, we_f,
        input  addr_a, addr_b, addr_f, wdata_a, wdata_b, wdata_f,
        input  clear_start, ram_rdata,
        output ack_a, ack_b, ack_f, rdata, clear_done, busy,
        output ram_addr, ram_we, ram_wdata
    );

    modport master (
        output req_a, req_b, req_f, we_a, we_b, we_f,
        output addr_a, addr_b, addr_f, wdata_a, wdata_b, wdata_f,
        output clear_start, ram_rdata,
        input  ack_a, ack_b, ack_f, rdata, clear_done, busy,
        input  ram_addr, ram_we, ram_wdata
    );
endinterface

// File: rtl/snake_ram_arbiter.sv
// Snake RAM port-A arbiter (A/B/F round-robin, or fixed A>B>F with SNAKE_ARB_FIXED_PRIO_EN) plus zero-fill engine.
// Latency: grant sampled in IDLE, RAM driven next cycle, ack the cycle after; requests wait (held) while busy or clearing.
module snake_ram_arbiter #(
    parameter int AW    = 13,
    parameter int DW    = 16,
    parameter int DEPTH = 8192
) (
    input  logic              clk,
    input  logic              rst,
    snake_ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_ACC, ST_RESP, ST_CLEAR} state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_ram_addr, w_addr_nxt;
    logic          r_ram_we, w_we_nxt;
    logic [DW-1:0] r_ram_wdata, w_wdata_nxt;
    logic [1:0]    r_win, w_win_nxt;
    logic          r_clear_pend, w_pend_nxt;
    logic          r_clear_done, w_done_nxt;
    logic [1:0]    w_grant;
    logic          w_any;
    logic [AW-1:0] w_sel_addr;
    logic          w_sel_we;
    logic [DW-1:0] w_sel_wdata;
    logic          w_resp;

    assign w_any = bus.req_a | bus.req_b | bus.req_f;

`ifdef SNAKE_ARB_FIXED_PRIO_EN
    always_comb begin
        if (bus.req_a)      w_grant = 2'd0;
        else if (bus.req_b) w_grant = 2'd1;
        else                w_grant = 2'd2;
    end
`else
    logic [1:0] r_rr, w_rr_nxt;

    // Search order starts at the pointer: 0 = A,B,F  1 = B,F,A  2 = F,A,B.
    always_comb begin
        w_grant = 2'd0;
        case (r_rr)
            2'd1:    w_grant = bus.req_b ? 2'd1 : (bus.req_f ? 2'd2 : 2'd0);
            2'd2:    w_grant = bus.req_f ? 2'd2 : (bus.req_a ? 2'd0 : 2'd1);
            default: w_grant = bus.req_a ? 2'd0 : (bus.req_b ? 2'd1 : 2'd2);
        endcase
    end
`endif

    always_comb begin
        w_sel_addr  = bus.addr_f;
        w_sel_we    = bus.we_f;
        w_sel_wdata = bus.wdata_f;
        case (w_grant)
            2'd0: begin
                w_sel_addr  = bus.addr_a;
                w_sel_we    = bus.we_a;
                w_sel_wdata = bus.wdata_a;
            end
            2'd1: begin
                w_sel_addr  = bus.addr_b;
                w_sel_we    = bus.we_b;
                w_sel_wdata = bus.wdata_b;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_ram_addr;
        w_we_nxt    = r_ram_we;
        w_wdata_nxt = r_ram_wdata;
        w_win_nxt   = r_win;
        w_pend_nxt  = r_clear_pend;
        w_done_nxt  = 1'b0;
`ifndef SNAKE_ARB_FIXED_PRIO_EN
        w_rr_nxt    = r_rr;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.clear_start || r_clear_pend) begin
                    w_state_nxt = ST_CLEAR;
                    w_addr_nxt  = '0;
                    w_we_nxt    = 1'b1;
                    w_wdata_nxt = '0;
                    w_pend_nxt  = 1'b0;
                end else if (w_any) begin
                    w_state_nxt = ST_ACC;
                    w_win_nxt   = w_grant;
                    w_addr_nxt  = w_sel_addr;
                    w_we_nxt    = w_sel_we;
                    w_wdata_nxt = w_sel_wdata;
                end
            end
            ST_ACC: begin
                w_we_nxt    = 1'b0;
                w_state_nxt = ST_RESP;
                if (bus.clear_start) w_pend_nxt = 1'b1;
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
                if (bus.clear_start) w_pend_nxt = 1'b1;
`ifndef SNAKE_ARB_FIXED_PRIO_EN
                w_rr_nxt = (r_win == 2'd2) ? 2'd0 : r_win + 2'd1;
`endif
            end
            ST_CLEAR: begin
                // clear_start here is deliberately ignored: the fill never restarts.
                if (r_ram_addr == LAST_ADDR) begin
                    w_we_nxt    = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_addr_nxt = r_ram_addr + AW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_ram_addr   <= '0;
            r_ram_we     <= 1'b0;
            r_ram_wdata  <= '0;
            r_win        <= 2'd0;
            r_clear_pend <= 1'b0;
            r_clear_done <= 1'b0;
`ifndef SNAKE_ARB_FIXED_PRIO_EN
            r_rr         <= 2'd0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_ram_addr   <= w_addr_nxt;
            r_ram_we     <= w_we_nxt;
            r_ram_wdata  <= w_wdata_nxt;
            r_win        <= w_win_nxt;
            r_clear_pend <= w_pend_nxt;
            r_clear_done <= w_done_nxt;
`ifndef SNAKE_ARB_FIXED_PRIO_EN
            r_rr         <= w_rr_nxt;
`endif
        end
    end

    assign w_resp         = (r_state == ST_RESP);
    assign bus.ack_a      = w_resp && (r_win == 2'd0);
    assign bus.ack_b      = w_resp && (r_win == 2'd1);
    assign bus.ack_f      = w_resp && (r_win == 2'd2);
    assign bus.rdata      = bus.ram_rdata;
    assign bus.clear_done = r_clear_done;
    assign bus.busy       = (r_state != ST_IDLE);
    assign bus.ram_addr   = r_ram_addr;
    assign bus.ram_we     = r_ram_we;
    assign bus.ram_wdata  = r_ram_wdata;
endmodule

// File: tb/tb_snake_ram_arbiter.sv
// Directed bench for snake_ram_arbiter (DEPTH overridden to 16), with a 1-cycle-latency RAM model on port A.
module tb_snake_ram_arbiter;
    localparam int AW = 13;
    localparam int DW = 16;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    snake_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    snake_ram_arbiter #(.AW(AW), .DW(DW), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    task automatic idle_inputs();
        bus.req_a = 1'b0; bus.req_b = 1'b0; bus.req_f = 1'b0;
        bus.we_a = 1'b0;  bus.we_b = 1'b0;  bus.we_f = 1'b0;
        bus.addr_a = '0;  bus.addr_b = '0;  bus.addr_f = '0;
        bus.wdata_a = '0; bus.wdata_b = '0; bus.wdata_f = '0;
        bus.clear_start = 1'b0;
    endtask

    task automatic set_req(input int who, input logic v, input logic we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        case (who)
            0: begin bus.req_a = v; bus.we_a = we; bus.addr_a = addr; bus.wdata_a = wd; end
            1: begin bus.req_b = v; bus.we_b = we; bus.addr_b = addr; bus.wdata_b = wd; end
            default: begin bus.req_f = v; bus.we_f = we; bus.addr_f = addr; bus.wdata_f = wd; end
        endcase
    endtask

    // Drives one access from the current cycle (cycle 0) and records what was observed; no checking here.
    task automatic run_access(input int who, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wd, output logic [DW-1:0] rd,
                              output int ack_cyc, output logic [2:0] ackv,
                              output logic c1_we, output logic [AW-1:0] c1_addr,
                              output logic [DW-1:0] c1_wdata, output logic [3:0] busy_mask);
        logic acked;
        ack_cyc = -1; rd = '0; ackv = '0; c1_we = 1'b0; c1_addr = '0; c1_wdata = '0;
        busy_mask = '0; acked = 1'b0;
        set_req(who, 1'b1, we, addr, wd);
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
                if (acked) set_req(who, 1'b0, 1'b0, '0, '0);
            end
            @(negedge clk);
            if (cyc < 4) busy_mask[cyc] = bus.busy;
            if (cyc == 1) begin
                c1_we = bus.ram_we; c1_addr = bus.ram_addr; c1_wdata = bus.ram_wdata;
            end
            if (!acked && ((who == 0 && bus.ack_a) || (who == 1 && bus.ack_b) || (who == 2 && bus.ack_f))) begin
                acked = 1'b1; ack_cyc = cyc; rd = bus.rdata;
                ackv = {bus.ack_f, bus.ack_b, bus.ack_a};
            end
            if (acked && cyc >= 3) break;
        end
        set_req(who, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        #23;
        checks++;
        if ({bus.ack_a, bus.ack_b, bus.ack_f, bus.clear_done, bus.busy, bus.ram_we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected 000000",
                     {bus.ack_a, bus.ack_b, bus.ack_f, bus.clear_done, bus.busy, bus.ram_we});
        end
        checks++;
        if (bus.ram_addr !== '0 || bus.ram_wdata !== '0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h wdata=%h, expected 0/0", bus.ram_addr, bus.ram_wdata);
        end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_write_latency();
        logic [DW-1:0] rd; int ac; logic [2:0] av; logic we1; logic [AW-1:0] a1;
        logic [DW-1:0] d1; logic [3:0] bm;
        @(posedge clk); #1;
        run_access(0, 1'b1, 13'h0010, 16'hABCD, rd, ac, av, we1, a1, d1, bm);
        checks++;
        if ({we1, a1, d1} !== {1'b1, 13'h0010, 16'hABCD}) begin
            errors++;
            $display("FAIL wr_cycle1: we=%b addr=%h data=%h, expected 1/0010/abcd", we1, a1, d1);
        end
        checks++;
        if (ac !== 2 || av !== 3'b001) begin
            errors++;
            $display("FAIL wr_ack_a: cycle=%0d acks=%b, expected 2/001", ac, av);
        end
        checks++;
        if (bm !== 4'b0110) begin
            errors++;
            $display("FAIL wr_busy: busy cycles 3..0=%b, expected 0110", bm);
        end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] rd; int ac; logic [2:0] av; logic we1; logic [AW-1:0] a1;
        logic [DW-1:0] d1; logic [3:0] bm;
        @(posedge clk); #1;
        run_access(1, 1'b1, 13'h0005, 16'h1234, rd, ac, av, we1, a1, d1, bm);
        checks++;
        if (ac !== 2 || av !== 3'b010 || we1 !== 1'b1) begin
            errors++;
            $display("FAIL b_write: cycle=%0d acks=%b we=%b, expected 2/010/1", ac, av, we1);
        end
        @(posedge clk); #1;
        run_access(2, 1'b0, 13'h0005, 16'h0000, rd, ac, av, we1, a1, d1, bm);
        checks++;
        if (ac !== 2 || av !== 3'b100) begin
            errors++;
            $display("FAIL f_read_ack: cycle=%0d acks=%b, expected 2/100", ac, av);
        end
        checks++;
        if (rd !== 16'h1234) begin
            errors++;
            $display("FAIL f_read_data: rdata=%h, expected 1234", rd);
        end
        checks++;
        if (we1 !== 1'b0 || a1 !== 13'h0005) begin
            errors++;
            $display("FAIL f_read_bus: we=%b addr=%h, expected 0/0005", we1, a1);
        end
    endtask

    task automatic test_round_robin();
        int exp_order [6];
        int got_who;
        int last_cyc;
        int n;
`ifdef SNAKE_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 0, 1, 2};
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        set_req(0, 1'b1, 1'b0, 13'h0001, '0);
        set_req(1, 1'b1, 1'b0, 13'h0002, '0);
        set_req(2, 1'b1, 1'b0, 13'h0003, '0);
        @(negedge clk); rst = 1'b0;
        n = 0; last_cyc = 0;
        for (int cyc = 0; cyc < 40 && n < 6; cyc++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (bus.ack_a || bus.ack_b || bus.ack_f) begin
                got_who = bus.ack_a ? 0 : (bus.ack_b ? 1 : 2);
                checks++;
                if (got_who !== exp_order[n] || ({2'b0, bus.ack_a} + {2'b0, bus.ack_b} + {2'b0, bus.ack_f}) !== 3'd1) begin
                    errors++;
                    $display("FAIL rr_grant%0d: acks(f,b,a)=%b, expected requester %0d", n,
                             {bus.ack_f, bus.ack_b, bus.ack_a}, exp_order[n]);
                end
                if (n > 0) begin
                    checks++;
                    if (cyc - last_cyc !== 3) begin
                        errors++;
                        $display("FAIL rr_spacing%0d: gap=%0d, expected 3", n, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                n++;
            end
        end
        checks++;
        if (n !== 6) begin
            errors++;
            $display("FAIL rr_count: got %0d acks, expected 6", n);
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic test_clear();
        int done_cnt;
        @(posedge clk); #1;
        for (int cyc = 0; cyc <= 20; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            if (cyc == 0) bus.clear_start = 1'b1;
            if (cyc == 1) bus.clear_start = 1'b0;
            if (cyc == 5) set_req(0, 1'b1, 1'b0, 13'h0005, '0);
            if (cyc == 20) set_req(0, 1'b0, 1'b0, '0, '0);
            @(negedge clk);
            if (cyc >= 1 && cyc <= 16) begin
                checks++;
                if ({bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.ack_a, bus.clear_done} !==
                    {1'b1, 13'(cyc - 1), 16'h0000, 1'b0, 1'b0}) begin
                    errors++;
                    $display("FAIL clr_cycle%0d: we=%b addr=%h data=%h ack_a=%b done=%b, expected 1/%h/0000/0/0",
                             cyc, bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.ack_a, bus.clear_done, 13'(cyc - 1));
                end
            end
            if (cyc == 17) begin
                checks++;
                if (bus.clear_done !== 1'b1 || bus.ram_we !== 1'b0 || bus.busy !== 1'b0) begin
                    errors++;
                    $display("FAIL clr_done: done=%b we=%b busy=%b, expected 1/0/0",
                             bus.clear_done, bus.ram_we, bus.busy);
                end
            end
            if (cyc == 18) begin
                checks++;
                if (bus.clear_done !== 1'b0 || bus.ram_addr !== 13'h0005 || bus.ram_we !== 1'b0) begin
                    errors++;
                    $display("FAIL clr_then_grant: done=%b addr=%h we=%b, expected 0/0005/0",
                             bus.clear_done, bus.ram_addr, bus.ram_we);
                end
            end
            if (cyc == 19) begin
                checks++;
                if (bus.ack_a !== 1'b1 || bus.rdata !== 16'h0000) begin
                    errors++;
                    $display("FAIL clr_read_back: ack_a=%b rdata=%h, expected 1/0000", bus.ack_a, bus.rdata);
                end
            end
        end
        done_cnt = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            if (bus.clear_done || bus.ack_a) done_cnt++;
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++;
            $display("FAIL clr_quiet: %0d stray done/ack cycles, expected 0", done_cnt);
        end
    endtask

    task automatic test_clear_during_resp();
        int ackb_cyc, done_cyc, first_clr, we_cnt;
        logic busy3;
        ackb_cyc = -1; done_cyc = -1; first_clr = -1; we_cnt = 0; busy3 = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 0; cyc <= 25; cyc++) begin
            if (cyc > 0) begin @(posedge clk); #1; end
            if (cyc == 0) set_req(1, 1'b1, 1'b1, 13'h0007, 16'h5555);
            if (cyc == 2) bus.clear_start = 1'b1;
            if (cyc == 3) begin bus.clear_start = 1'b0; set_req(1, 1'b0, 1'b0, '0, '0); end
            if (cyc == 8) bus.clear_start = 1'b1;
            if (cyc == 9) bus.clear_start = 1'b0;
            @(negedge clk);
            if (bus.ack_b && ackb_cyc < 0) ackb_cyc = cyc;
            if (bus.clear_done && done_cyc < 0) done_cyc = cyc;
            if (cyc >= 3 && bus.ram_we) begin
                we_cnt++;
                if (first_clr < 0) first_clr = cyc;
            end
            if (cyc == 3) busy3 = bus.busy;
        end
        checks++;
        if (ackb_cyc !== 2) begin
            errors++;
            $display("FAIL resp_clr_ack_b: ack at cycle %0d, expected 2", ackb_cyc);
        end
        checks++;
        if (first_clr !== 4 || busy3 !== 1'b0) begin
            errors++;
            $display("FAIL resp_clr_start: first fill cycle %0d busy3=%b, expected 4/0", first_clr, busy3);
        end
        checks++;
        if (we_cnt !== 16 || done_cyc !== 20) begin
            errors++;
            $display("FAIL resp_clr_len: writes=%0d done at %0d, expected 16/20", we_cnt, done_cyc);
        end
    endtask

    task automatic test_reset_mid_access();
        int stray;
        @(posedge clk); #1;
        set_req(0, 1'b1, 1'b1, 13'h0020, 16'h7777);
        @(posedge clk); #2;
        checks++;
        if (bus.ram_we !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_acc: we=%b busy=%b, expected 1/1", bus.ram_we, bus.busy);
        end
        rst = 1'b1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        #1;
        checks++;
        if ({bus.ram_we, bus.busy, bus.ram_addr, bus.ram_wdata, bus.ack_a} !== '0) begin
            errors++;
            $display("FAIL rst_async: we=%b busy=%b addr=%h data=%h ack_a=%b, expected all 0",
                     bus.ram_we, bus.busy, bus.ram_addr, bus.ram_wdata, bus.ack_a);
        end
        @(negedge clk); rst = 1'b0;
        stray = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            if (bus.ack_a || bus.ack_b || bus.ack_f || bus.clear_done || bus.busy) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("FAIL rst_no_ack: %0d active cycles after reset, expected 0", stray);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_write_latency();
        test_write_read();
        test_clear();
        test_clear_during_resp();
        test_round_robin();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
